// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: word/pc widths,
// the 3-bit opcode encodings (ADV..CDV) and the fetch FSM state encodings.
package instruction_fetch_pkg;

  localparam int PC_W   = 5;
  localparam int WORD_W = 3;

  // Opcode encodings of the 3-bit machine.
  localparam logic [WORD_W-1:0] OP_ADV = 3'd0;
  localparam logic [WORD_W-1:0] OP_BXL = 3'd1;
  localparam logic [WORD_W-1:0] OP_BST = 3'd2;
  localparam logic [WORD_W-1:0] OP_JNZ = 3'd3;
  localparam logic [WORD_W-1:0] OP_BXC = 3'd4;
  localparam logic [WORD_W-1:0] OP_OUT = 3'd5;
  localparam logic [WORD_W-1:0] OP_BDV = 3'd6;
  localparam logic [WORD_W-1:0] OP_CDV = 3'd7;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } if_state_e;

endpackage

// File: rtl/instruction_fetch_prog_mem.sv
// Program memory for instruction_fetch: one synchronous write port and two
// combinational read ports (pc and pc+1). Contents are never reset.
// Out-of-range addresses read as zero and out-of-range writes are ignored.
module instruction_fetch_prog_mem
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [PC_W-1:0]   i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [PC_W-1:0]   i_raddr0,
  input  logic [PC_W-1:0]   i_raddr1,
  output logic [WORD_W-1:0] o_rdata0,
  output logic [WORD_W-1:0] o_rdata1
);

  localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_W-1:0] DEPTH_W = PC_W'(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Write port: store one accepted load word.
  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr < DEPTH_W)) begin
      r_mem[i_waddr[IW-1:0]] <= i_wdata;
    end
  end

  // Read ports: combinational, zero outside the array.
  always_comb begin
    o_rdata0 = '0;
    o_rdata1 = '0;
    if (i_raddr0 < DEPTH_W) o_rdata0 = r_mem[i_raddr0[IW-1:0]];
    if (i_raddr1 < DEPTH_W) o_rdata1 = r_mem[i_raddr1[IW-1:0]];
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: loads a program of 3-bit words into prog_mem, then
// fetches (opcode, operand) pairs two words at a time with jump/flush and
// stall handling. Optional macro IF_DEBUG_COUNT_EN adds pc_dbg and a
// saturating instr_cnt output.
//
// Load handshake: a word is transferred in any cycle where prog_valid and
// prog_ready are both 1; prog_ready is 1 only in IDLE and LOAD and does not
// depend on prog_valid.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int PROG_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_valid,
  input  logic [WORD_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  input  logic              start,
  input  logic              halt_if,
  input  logic              jmp_en,
  input  logic [WORD_W-1:0] jmp_target,
  output logic [WORD_W-1:0] opcode_if_reg,
  output logic [WORD_W-1:0] operand_if_reg,
  output logic              valid_if,
  output logic              done,
  output logic              load_ovf
`ifdef IF_DEBUG_COUNT_EN
  ,
  output logic [PC_W-1:0]   pc_dbg,
  output logic [15:0]       instr_cnt
`endif
);

  localparam logic [PC_W-1:0] DEPTH_W = PC_W'(PROG_DEPTH);

  if_state_e         r_state;
  if_state_e         w_state_next;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_wr_ptr;
  logic [PC_W-1:0]   r_prog_len;
  logic [WORD_W-1:0] r_opcode;
  logic [WORD_W-1:0] r_operand;
  logic              r_valid;
  logic              r_load_ovf;

  logic              w_accept;
  logic              w_we;
  logic [PC_W-1:0]   w_load_base;
  logic [PC_W:0]     w_pc_p1;
  logic              w_fetch_ok;
  logic              w_start_run;
  logic [WORD_W-1:0] w_rd_op;
  logic [WORD_W-1:0] w_rd_opd;

  // A load starting from IDLE writes from index 0 so it replaces the program.
  assign w_accept    = prog_valid && prog_ready;
  assign w_load_base = (r_state == ST_IDLE) ? '0 : r_wr_ptr;
  assign w_we        = w_accept && (w_load_base < DEPTH_W);
  // pc+1 is one bit wider so the end-of-program compare never wraps.
  assign w_pc_p1     = {1'b0, r_pc} + (PC_W + 1)'(1);
  assign w_fetch_ok  = w_pc_p1 < {1'b0, r_prog_len};
  // prog_valid wins over start in IDLE; a program needs at least one pair.
  assign w_start_run = (r_state == ST_IDLE) && !prog_valid && start &&
                       (r_prog_len >= PC_W'(2));

  instruction_fetch_prog_mem #(
    .DEPTH(PROG_DEPTH)
  ) u_prog_mem (
    .i_clk    (clk),
    .i_we     (w_we),
    .i_waddr  (w_load_base),
    .i_wdata  (prog_data),
    .i_raddr0 (r_pc),
    .i_raddr1 (w_pc_p1[PC_W-1:0]),
    .o_rdata0 (w_rd_op),
    .o_rdata1 (w_rd_opd)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (prog_valid)       w_state_next = prog_last ? ST_IDLE : ST_LOAD;
        else if (w_start_run) w_state_next = ST_RUN;
      end
      ST_LOAD: begin
        if (prog_valid && prog_last) w_state_next = ST_IDLE;
      end
      ST_RUN: begin
        if (!jmp_en && !halt_if && !w_fetch_ok) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start || prog_valid) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    prog_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    done       = (r_state == ST_DONE);
  end

  // Load bookkeeping: write pointer, program length and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_prog_len <= '0;
      r_load_ovf <= 1'b0;
    end else if (w_accept) begin
      if (w_we) begin
        r_wr_ptr   <= w_load_base + PC_W'(1);
        r_prog_len <= w_load_base + PC_W'(1);
        if (r_state == ST_IDLE) r_load_ovf <= 1'b0;
      end else begin
        r_load_ovf <= 1'b1;
        r_prog_len <= DEPTH_W;
      end
    end
  end

  // Fetch datapath: pc, registered pair and valid; jump beats stall beats fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_opcode  <= '0;
      r_operand <= '0;
      r_valid   <= 1'b0;
    end else if (w_start_run) begin
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (jmp_en) begin
        r_pc    <= PC_W'(jmp_target);
        r_valid <= 1'b0;
      end else if (!halt_if) begin
        if (w_fetch_ok) begin
          r_opcode  <= w_rd_op;
          r_operand <= w_rd_opd;
          r_valid   <= 1'b1;
          r_pc      <= r_pc + PC_W'(2);
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign opcode_if_reg  = r_opcode;
  assign operand_if_reg = r_operand;
  assign valid_if       = r_valid;
  assign load_ovf       = r_load_ovf;

`ifdef IF_DEBUG_COUNT_EN
  logic [15:0] r_instr_cnt;

  // Count registered instructions since the last start, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
    end else if (w_start_run) begin
      r_instr_cnt <= '0;
    end else if ((r_state == ST_RUN) && !jmp_en && !halt_if && w_fetch_ok &&
                 (r_instr_cnt != 16'hFFFF)) begin
      r_instr_cnt <= r_instr_cnt + 16'd1;
    end
  end

  assign pc_dbg    = r_pc;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (default build, PROG_DEPTH=16).
module tb_instruction_fetch;

  logic       clk;
  logic       rst_n;
  logic       prog_valid;
  logic [2:0] prog_data;
  logic       prog_last;
  logic       prog_ready;
  logic       start;
  logic       halt_if;
  logic       jmp_en;
  logic [2:0] jmp_target;
  logic [2:0] opcode_if_reg;
  logic [2:0] operand_if_reg;
  logic       valid_if;
  logic       done;
  logic       load_ovf;

  int n_checks;
  int n_fail;

  instruction_fetch #(.PROG_DEPTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .prog_valid     (prog_valid),
    .prog_data      (prog_data),
    .prog_last      (prog_last),
    .prog_ready     (prog_ready),
    .start          (start),
    .halt_if        (halt_if),
    .jmp_en         (jmp_en),
    .jmp_target     (jmp_target),
    .opcode_if_reg  (opcode_if_reg),
    .operand_if_reg (operand_if_reg),
    .valid_if       (valid_if),
    .done           (done),
    .load_ovf       (load_ovf)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table row: inputs for one cycle and outputs expected after its edge.
  // Expected word layout: {ready, valid, opcode, operand, done, ovf}.
  typedef struct packed {
    logic       pv;
    logic [2:0] pd;
    logic       pl;
    logic       st;
    logic       hl;
    logic       je;
    logic [2:0] jt;
    logic [9:0] exp;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic pv, input logic [2:0] pd, input logic pl,
                              input logic st, input logic hl, input logic je,
                              input logic [2:0] jt, input logic rdy, input logic val,
                              input logic [2:0] op, input logic [2:0] opd,
                              input logic dn, input logic ovf);
    vec_t v;
    v.pv = pv; v.pd = pd; v.pl = pl; v.st = st; v.hl = hl; v.je = je; v.jt = jt;
    v.exp = {rdy, val, op, opd, dn, ovf};
    return v;
  endfunction

  function automatic logic [9:0] outs();
    return {prog_ready, valid_if, opcode_if_reg, operand_if_reg, done, load_ovf};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Driver: apply inputs at the falling edge, return 1 time unit after the rising edge.
  task automatic cyc(input logic pv, input logic [2:0] pd, input logic pl, input logic st,
                     input logic hl, input logic je, input logic [2:0] jt);
    @(negedge clk);
    prog_valid = pv; prog_data = pd; prog_last = pl;
    start = st; halt_if = hl; jmp_en = je; jmp_target = jt;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] w [17];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    prog_valid = 0; prog_data = 0; prog_last = 0;
    start = 0; halt_if = 0; jmp_en = 0; jmp_target = 0;

    //          pv pd pl st hl je jt   rdy v op opd dn ovf
    vecs[0]  = mk(1, 2, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 4, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 7, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 5, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // start -> RUN
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 4, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 7, 5, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 7, 5, 1, 0);  // DONE
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 7, 5, 1, 0);
    vecs[12] = mk(0, 0, 0, 1, 0, 0, 0,  1, 0, 7, 5, 0, 0);  // DONE -> IDLE
    vecs[13] = mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 7, 5, 0, 0);  // -> RUN
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 4, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 2, 4, 0, 0);  // jump to 0, flush
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 4, 0, 0);  // refetch
    vecs[17] = mk(0, 0, 0, 0, 1, 0, 0,  0, 1, 2, 4, 0, 0);  // halt x3
    vecs[18] = mk(0, 0, 0, 0, 1, 0, 0,  0, 1, 2, 4, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 1, 0, 0,  0, 1, 2, 4, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 0);
    vecs[21] = mk(0, 0, 0, 1, 0, 0, 0,  0, 1, 7, 5, 0, 0);  // start in RUN ignored
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 7, 5, 1, 0);
    vecs[23] = mk(0, 0, 0, 1, 0, 0, 0,  1, 0, 7, 5, 0, 0);
    vecs[24] = mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 7, 5, 0, 0);
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 4, 0, 0);
    vecs[26] = mk(0, 0, 0, 0, 1, 1, 4,  0, 0, 2, 4, 0, 0);  // jump beats halt
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 7, 5, 0, 0);
    vecs[28] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 7, 5, 1, 0);
    vecs[29] = mk(0, 0, 0, 1, 0, 0, 0,  1, 0, 7, 5, 0, 0);
    vecs[30] = mk(0, 0, 0, 1, 0, 1, 4,  0, 0, 7, 5, 0, 0);  // jmp_en in IDLE ignored
    vecs[31] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 4, 0, 0);
    vecs[32] = mk(0, 0, 0, 0, 0, 1, 5,  0, 0, 2, 4, 0, 0);  // jump past end
    vecs[33] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 4, 1, 0);
    vecs[34] = mk(1, 3, 1, 0, 0, 0, 0,  1, 0, 2, 4, 0, 0);  // prog_valid exits DONE, no accept
    vecs[35] = mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 2, 4, 0, 0);
    vecs[36] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 4, 0, 0);

    for (int i = 0; i < 17; i++) w[i] = 3'((i * 3 + 1) % 8);

    // Reset state.
    #12;
    check("reset_state", outs(), 10'b1_0_000_000_0_0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: load, run, jump, halt, combined jump/halt, jump past end.
    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].pv, vecs[i].pd, vecs[i].pl, vecs[i].st, vecs[i].hl, vecs[i].je, vecs[i].jt);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    prog_valid = 0; start = 0; halt_if = 0; jmp_en = 0;
    rst_n = 1'b0;
    #1;
    check("reset_in_run", outs(), 10'b1_0_000_000_0_0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("start_no_reload", outs(), 10'b1_0_000_000_0_0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("still_idle", outs(), 10'b1_0_000_000_0_0);

    // Overflow: 17 words into a 16-word memory.
    for (int i = 0; i < 17; i++) begin
      cyc(1, w[i], (i == 16), 0, 0, 0, 0);
      if (i == 15) check("ovf_at_16", {9'd0, load_ovf}, 10'd0);
    end
    check("ovf_at_17", {8'd0, prog_ready, load_ovf}, 10'b11);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("ovf_start", {8'd0, valid_if, prog_ready}, 10'b00);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      check($sformatf("ovf_pair%0d", k), {3'd0, valid_if, opcode_if_reg, operand_if_reg},
            {3'd0, 1'b1, w[2*k], w[2*k+1]});
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("ovf_done", {8'd0, valid_if, done}, 10'b01);

    // A new load clears the overflow flag and replaces the program.
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 6, 0, 0, 0, 0, 0);
    check("reload_clears_ovf", {8'd0, prog_ready, load_ovf}, 10'b10);
    cyc(1, 3, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("reload_pair", outs(), 10'b0_1_110_011_0_0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("reload_done", outs(), 10'b0_0_110_011_1_0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter PROG_DEPTH, default 16, meaning program memory size in 3-bit words (even, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port prog_valid, input, 1 bit: load word present.
REQ-005 The block SHALL have port prog_data, input, 3 bits: load word.
REQ-006 The block SHALL have port prog_last, input, 1 bit: final load word.
REQ-007 The block SHALL have port prog_ready, output, 1 bit: load word accepted.
REQ-008 The block SHALL have port start, input, 1 bit: begin execution.
REQ-009 The block SHALL have port halt_if, input, 1 bit: pipeline stall, which holds all fetch outputs.
REQ-010 The block SHALL have port jmp_en, input, 1 bit: jump taken, from execute.
REQ-011 The block SHALL have port jmp_target, input, 3 bits: literal operand, the new word-index PC.
REQ-012 The block SHALL have port opcode_if_reg, output, 3 bits: fetched opcode to decode.
REQ-013 The block SHALL have port operand_if_reg, output, 3 bits: fetched operand to decode.
REQ-014 The block SHALL have port valid_if, output, 1 bit: opcode/operand pair is a real instruction.
REQ-015 The block SHALL have port done, output, 1 bit: program halted (PC past end).
REQ-016 The block SHALL have port load_ovf, output, 1 bit: sticky flag, load exceeded PROG_DEPTH.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-018 IDLE SHALL go to LOAD on prog_valid, and to RUN on start when prog_len >= 2.
REQ-019 In IDLE or LOAD, prog_ready SHALL be 1, and a word SHALL be accepted in any cycle where prog_valid=1.
REQ-020 An accepted word SHALL be written to mem[wr_ptr], wr_ptr SHALL increment, and prog_len SHALL become wr_ptr+1.
REQ-021 An accepted word with prog_last=1 SHALL return the FSM to IDLE.
REQ-022 A word accepted at wr_ptr = PROG_DEPTH SHALL be dropped and SHALL set load_ovf; prog_len SHALL saturate at PROG_DEPTH.
REQ-023 Entering LOAD from IDLE SHALL clear wr_ptr and load_ovf first, so each load replaces the program.
REQ-024 On the start edge the block SHALL clear pc to 0 and valid_if to 0.
REQ-025 In RUN with halt_if=0 and jmp_en=0, if pc+1 < prog_len, the block SHALL register opcode=mem[pc], operand=mem[pc+1] and valid_if=1, and pc SHALL advance by 2, giving 1-cycle latency.
REQ-026 In RUN with pc+1 >= prog_len, the FSM SHALL go to DONE, with valid_if=0 and done=1.
REQ-027 jmp_en=1 SHALL have priority over halt_if and normal fetch: pc SHALL load jmp_target, and valid_if SHALL be 0 next cycle to flush the wrong-path pair.
REQ-028 A jmp_target with target+1 >= prog_len SHALL lead to DONE on the following fetch.
REQ-029 When halt_if=1 and jmp_en=0, pc, opcode_if_reg, operand_if_reg and valid_if SHALL all hold.
REQ-030 When valid_if=0, opcode_if_reg and operand_if_reg SHALL hold their last values.
REQ-031 DONE SHALL hold done=1 and valid_if=0, and SHALL go to IDLE on start or prog_valid; done SHALL clear on that exit.
REQ-032 pc SHALL be 5 bits wide, and the pc+2 arithmetic SHALL not wrap below 32.
REQ-033 start in LOAD or RUN SHALL be ignored.
REQ-034 The block SHALL ignore jmp_en outside RUN.

Reset
REQ-035 rst_n low SHALL asynchronously force: state=IDLE, pc=0, wr_ptr=0, prog_len=0, opcode_if_reg=0, operand_if_reg=0, valid_if=0, done=0 and load_ovf=0.
REQ-036 Program memory contents SHALL not be reset.
REQ-037 Reset during LOAD or RUN SHALL abandon the operation and SHALL require a full reload.

Configuration
REQ-038 When macro IF_DEBUG_COUNT_EN is defined, the block SHALL add outputs pc_dbg (5 bits, current pc) and instr_cnt (16 bits).
REQ-039 instr_cnt SHALL clear on start and increment on each cycle that registers valid_if=1, saturating at 16'hFFFF.
REQ-040 When IF_DEBUG_COUNT_EN is undefined, these ports and the counter SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-041 The FSM state encodings SHALL live in the shared opcode/select defines header, alongside the ADV..CDV opcode defines.
REQ-042 Program memory SHALL be a sub-module prog_mem with one write port and two combinational read ports (pc, pc+1).
REQ-043 All FSM, pc and flush logic SHALL stay in instruction_fetch.

Verification
REQ-044 Test: load 2,4,1,1,7,5 with prog_last on the final word, then start; required response: pairs (2,4), (1,1), (7,5) with valid_if=1 on consecutive cycles, then done=1 one cycle later.
REQ-045 Test: jmp_en=1 with target=0 asserted while pair (1,1) is being fetched; required response: valid_if=0 for one cycle, then (2,4) is refetched.
REQ-046 Test: halt_if=1 held for 3 cycles mid-run; required response: outputs and pc frozen, with no pair skipped or duplicated after release.
REQ-047 Test: load 17 words into PROG_DEPTH=16; required response: load_ovf=1, prog_len=16, and the 17th word is not written.
REQ-048 Test: jmp_en and halt_if asserted together with target=4 on a 6-word program; required response: jump taken, and the next valid pair is (mem[4], mem[5]).
REQ-049 Test: assert rst_n low during RUN; required response: all outputs return to 0 immediately, and start without a reload stays in IDLE.
